// File: rtl/add_sub_reservation_station.sv
// rtl/add_sub_reservation_station.sv - reservation station buffering add/sub ops for one add_sub_unit
//
// Purpose: holds up to RS_SIZE dispatched add/sub instructions, snoops the CDB for
// missing op1/op2/XER operands, and issues the lowest-index fully-ready entry to the
// add_sub_unit, tagged with its global RS id (RS_ID_BASE + entry index).
//
// Ports:
//   clk, rst (sync, active-low), flush       - clock, reset, discard all entries
//   dispatch_*                                - dispatch handshake, decoded op, operands/tags
//   cdb_*                                     - common data bus broadcast (GPR result, optional XER)
//   issue_*                                   - issue handshake and operand/control payload
//   occupancy                                 - registered count of busy entries

package add_sub_rs_pkg;
  typedef struct packed {
    logic subtract;
    logic add_ca;
    logic alter_ca;
    logic alter_ov;
    logic alter_cr0;
  } add_sub_decode_t;
endpackage

module add_sub_reservation_station
  import add_sub_rs_pkg::*;
#(
  parameter int RS_ID_WIDTH = 5,
  parameter int RS_SIZE     = 4,
  parameter int RS_ID_BASE  = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         dispatch_valid,
  output logic                         dispatch_ready,
  input  add_sub_decode_t              dispatch_control,
  input  logic [4:0]                   dispatch_result_reg_addr,
  input  logic                         dispatch_op1_valid,
  input  logic                         dispatch_op2_valid,
  input  logic                         dispatch_xer_valid,
  input  logic [31:0]                  dispatch_op1,
  input  logic [31:0]                  dispatch_op2,
  input  logic [31:0]                  dispatch_xer,
  input  logic [RS_ID_WIDTH-1:0]       dispatch_op1_tag,
  input  logic [RS_ID_WIDTH-1:0]       dispatch_op2_tag,
  input  logic [RS_ID_WIDTH-1:0]       dispatch_xer_tag,
  input  logic                         cdb_valid,
  input  logic [RS_ID_WIDTH-1:0]       cdb_rs_id,
  input  logic [31:0]                  cdb_result,
  input  logic                         cdb_xer_valid,
  input  logic [31:0]                  cdb_xer,
  output logic                         issue_valid,
  input  logic                         issue_ready,
  output logic [RS_ID_WIDTH-1:0]       issue_rs_id,
  output logic [4:0]                   issue_result_reg_addr,
  output logic [31:0]                  issue_op1,
  output logic [31:0]                  issue_op2,
  output logic [31:0]                  issue_xer,
  output add_sub_decode_t              issue_control,
  output logic [$clog2(RS_SIZE+1)-1:0] occupancy
);

  localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;
  localparam int OCC_W = $clog2(RS_SIZE + 1);
  localparam int N_OPS = 3;  // operand slots: 0 = op1, 1 = op2, 2 = xer
  localparam int XER   = 2;

  // Entry storage
  logic [RS_SIZE-1:0]     busy_q, busy_d;
  add_sub_decode_t        ctrl_q [RS_SIZE];
  add_sub_decode_t        ctrl_d [RS_SIZE];
  logic [4:0]             rd_q   [RS_SIZE];
  logic [4:0]             rd_d   [RS_SIZE];
  logic [N_OPS-1:0]       opv_q  [RS_SIZE];
  logic [N_OPS-1:0]       opv_d  [RS_SIZE];
  logic [RS_ID_WIDTH-1:0] tag_q  [RS_SIZE][N_OPS];
  logic [RS_ID_WIDTH-1:0] tag_d  [RS_SIZE][N_OPS];
  logic [31:0]            val_q  [RS_SIZE][N_OPS];
  logic [31:0]            val_d  [RS_SIZE][N_OPS];
  logic [OCC_W-1:0]       occ_q, occ_d;

  // Dispatch operands and CDB capture rules arranged per operand slot
  logic [N_OPS-1:0]       d_valid;
  logic [RS_ID_WIDTH-1:0] d_tag [N_OPS];
  logic [31:0]            d_val [N_OPS];
  logic [N_OPS-1:0]       cdb_ok;
  logic [31:0]            cdb_val [N_OPS];

  assign d_valid  = {dispatch_xer_valid, dispatch_op2_valid, dispatch_op1_valid};
  assign d_tag[0] = dispatch_op1_tag;
  assign d_tag[1] = dispatch_op2_tag;
  assign d_tag[2] = dispatch_xer_tag;
  assign d_val[0] = dispatch_op1;
  assign d_val[1] = dispatch_op2;
  assign d_val[2] = dispatch_xer;

  // A broadcast only satisfies an XER dependency when it actually carries an XER update.
  assign cdb_ok     = {cdb_valid & cdb_xer_valid, cdb_valid, cdb_valid};
  assign cdb_val[0] = cdb_result;
  assign cdb_val[1] = cdb_result;
  assign cdb_val[2] = cdb_xer;

  // Free-slot and issue selection, both lowest index first, from registered state only
  logic             free_found, sel_found;
  logic [IDX_W-1:0] free_idx, sel_idx;

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    sel_found  = 1'b0;
    sel_idx    = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (busy_q[i] && (&opv_q[i])) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  logic dispatch_fire, issue_fire;

  assign dispatch_ready = free_found;
  assign issue_valid    = sel_found;
  assign dispatch_fire  = dispatch_valid & dispatch_ready;
  assign issue_fire     = issue_valid & issue_ready;

  // Next-state: wakeup, then issue free, then dispatch write, with flush overriding all
  always_comb begin
    busy_d = busy_q;
    ctrl_d = ctrl_q;
    rd_d   = rd_q;
    opv_d  = opv_q;
    tag_d  = tag_q;
    val_d  = val_q;

    for (int i = 0; i < RS_SIZE; i++) begin
      for (int k = 0; k < N_OPS; k++) begin
        if (busy_q[i] && !opv_q[i][k] && cdb_ok[k] && (tag_q[i][k] == cdb_rs_id)) begin
          opv_d[i][k] = 1'b1;
          val_d[i][k] = cdb_val[k];
        end
      end
    end

    if (issue_fire) begin
      busy_d[sel_idx] = 1'b0;
    end

    // The chosen free slot was free in registered state, so it never collides with
    // the issuing entry; a slot freed this cycle only becomes visible next cycle.
    if (dispatch_fire) begin
      busy_d[free_idx] = 1'b1;
      ctrl_d[free_idx] = dispatch_control;
      rd_d[free_idx]   = dispatch_result_reg_addr;
      for (int k = 0; k < N_OPS; k++) begin
        tag_d[free_idx][k] = d_tag[k];
        if (d_valid[k]) begin
          opv_d[free_idx][k] = 1'b1;
          val_d[free_idx][k] = d_val[k];
        end else if (cdb_ok[k] && (d_tag[k] == cdb_rs_id)) begin
          // Producer broadcasting in the dispatch cycle would otherwise be missed.
          opv_d[free_idx][k] = 1'b1;
          val_d[free_idx][k] = cdb_val[k];
        end else begin
          opv_d[free_idx][k] = 1'b0;
          val_d[free_idx][k] = '0;
        end
      end
    end

    if (flush) begin
      busy_d = '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        opv_d[i] = '0;
      end
    end
  end

  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else if (dispatch_fire && !issue_fire) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (!dispatch_fire && issue_fire) begin
      occ_d = occ_q - OCC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q <= '0;
      occ_q  <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        ctrl_q[i] <= '0;
        rd_q[i]   <= '0;
        opv_q[i]  <= '0;
        for (int k = 0; k < N_OPS; k++) begin
          tag_q[i][k] <= '0;
          val_q[i][k] <= '0;
        end
      end
    end else begin
      busy_q <= busy_d;
      occ_q  <= occ_d;
      ctrl_q <= ctrl_d;
      rd_q   <= rd_d;
      opv_q  <= opv_d;
      tag_q  <= tag_d;
      val_q  <= val_d;
    end
  end

  // Issue payload is forced to zero when nothing is selected.
  always_comb begin
    issue_rs_id           = '0;
    issue_result_reg_addr = '0;
    issue_op1             = '0;
    issue_op2             = '0;
    issue_xer             = '0;
    issue_control         = '0;
    if (sel_found) begin
      issue_rs_id           = RS_ID_WIDTH'(RS_ID_BASE) + RS_ID_WIDTH'(sel_idx);
      issue_result_reg_addr = rd_q[sel_idx];
      issue_op1             = val_q[sel_idx][0];
      issue_op2             = val_q[sel_idx][1];
      issue_xer             = val_q[sel_idx][XER];
      issue_control         = ctrl_q[sel_idx];
    end
  end

  assign occupancy = occ_q;

endmodule

// File: tb/tb_add_sub_reservation_station.sv
// tb/tb_add_sub_reservation_station.sv - directed self-checking bench for add_sub_reservation_station

module tb_add_sub_reservation_station;
  import add_sub_rs_pkg::*;

  logic            clk = 1'b0;
  logic            rst, flush;
  logic            dispatch_valid, dispatch_ready;
  add_sub_decode_t dispatch_control;
  logic [4:0]      dispatch_result_reg_addr;
  logic            dispatch_op1_valid, dispatch_op2_valid, dispatch_xer_valid;
  logic [31:0]     dispatch_op1, dispatch_op2, dispatch_xer;
  logic [4:0]      dispatch_op1_tag, dispatch_op2_tag, dispatch_xer_tag;
  logic            cdb_valid;
  logic [4:0]      cdb_rs_id;
  logic [31:0]     cdb_result;
  logic            cdb_xer_valid;
  logic [31:0]     cdb_xer;
  logic            issue_valid, issue_ready;
  logic [4:0]      issue_rs_id, issue_result_reg_addr;
  logic [31:0]     issue_op1, issue_op2, issue_xer;
  add_sub_decode_t issue_control;
  logic [2:0]      occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  add_sub_reservation_station #(
    .RS_ID_WIDTH(5), .RS_SIZE(4), .RS_ID_BASE(0)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
    .dispatch_control(dispatch_control), .dispatch_result_reg_addr(dispatch_result_reg_addr),
    .dispatch_op1_valid(dispatch_op1_valid), .dispatch_op2_valid(dispatch_op2_valid),
    .dispatch_xer_valid(dispatch_xer_valid),
    .dispatch_op1(dispatch_op1), .dispatch_op2(dispatch_op2), .dispatch_xer(dispatch_xer),
    .dispatch_op1_tag(dispatch_op1_tag), .dispatch_op2_tag(dispatch_op2_tag),
    .dispatch_xer_tag(dispatch_xer_tag),
    .cdb_valid(cdb_valid), .cdb_rs_id(cdb_rs_id), .cdb_result(cdb_result),
    .cdb_xer_valid(cdb_xer_valid), .cdb_xer(cdb_xer),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_rs_id(issue_rs_id),
    .issue_result_reg_addr(issue_result_reg_addr),
    .issue_op1(issue_op1), .issue_op2(issue_op2), .issue_xer(issue_xer),
    .issue_control(issue_control), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic v1, input logic [31:0] o1, input logic [4:0] t1,
                      input logic v2, input logic [31:0] o2, input logic [4:0] t2,
                      input logic vx, input logic [31:0] ox, input logic [4:0] tx);
    dispatch_valid     = 1'b1;
    dispatch_op1_valid = v1; dispatch_op1 = o1; dispatch_op1_tag = t1;
    dispatch_op2_valid = v2; dispatch_op2 = o2; dispatch_op2_tag = t2;
    dispatch_xer_valid = vx; dispatch_xer = ox; dispatch_xer_tag = tx;
  endtask

  task automatic nodisp();
    dispatch_valid = 1'b0;
  endtask

  task automatic cdb(input logic [4:0] id, input logic [31:0] res, input logic xv, input logic [31:0] x);
    cdb_valid = 1'b1; cdb_rs_id = id; cdb_result = res; cdb_xer_valid = xv; cdb_xer = x;
  endtask

  task automatic nocdb();
    cdb_valid = 1'b0; cdb_xer_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; flush = 1'b0; issue_ready = 1'b0;
    dispatch_valid = 1'b0; dispatch_control = '0; dispatch_result_reg_addr = '0;
    dispatch_op1_valid = 1'b0; dispatch_op2_valid = 1'b0; dispatch_xer_valid = 1'b0;
    dispatch_op1 = '0; dispatch_op2 = '0; dispatch_xer = '0;
    dispatch_op1_tag = '0; dispatch_op2_tag = '0; dispatch_xer_tag = '0;
    cdb_valid = 1'b0; cdb_rs_id = '0; cdb_result = '0; cdb_xer_valid = 1'b0; cdb_xer = '0;
    tick(); tick();
    rst = 1'b1;

    // Reset state
    check_eq("rst_issue_valid", 32'(issue_valid), 32'd0);
    check_eq("rst_dispatch_ready", 32'(dispatch_ready), 32'd1);
    check_eq("rst_occupancy", 32'(occupancy), 32'd0);
    check_eq("rst_issue_op1", issue_op1, 32'd0);

    // Single ready op, issued the cycle after dispatch
    issue_ready = 1'b1;
    dispatch_control = 5'b10101; dispatch_result_reg_addr = 5'd4;
    disp(1'b1, 32'd5, 5'd0, 1'b1, 32'd3, 5'd0, 1'b1, 32'd0, 5'd0);
    tick(); nodisp();
    check_eq("single_issue_valid", 32'(issue_valid), 32'd1);
    check_eq("single_rs_id", 32'(issue_rs_id), 32'd0);
    check_eq("single_op1", issue_op1, 32'd5);
    check_eq("single_op2", issue_op2, 32'd3);
    check_eq("single_reg", 32'(issue_result_reg_addr), 32'd4);
    check_eq("single_ctrl", 32'(issue_control), 32'h15);
    check_eq("single_occ", 32'(occupancy), 32'd1);
    tick();
    check_eq("single_occ_after", 32'(occupancy), 32'd0);
    check_eq("single_iv_after", 32'(issue_valid), 32'd0);
    dispatch_control = '0;

    // CDB wakeup of op2 two cycles after dispatch
    disp(1'b1, 32'd1, 5'd0, 1'b0, 32'hFFFF, 5'd7, 1'b1, 32'd0, 5'd0);
    tick(); nodisp();
    check_eq("wake_wait_iv", 32'(issue_valid), 32'd0);
    check_eq("wake_wait_occ", 32'(occupancy), 32'd1);
    tick();
    cdb(5'd7, 32'h10, 1'b0, 32'd0);
    check_eq("wake_bcast_iv", 32'(issue_valid), 32'd0);
    tick(); nocdb();
    check_eq("wake_iv", 32'(issue_valid), 32'd1);
    check_eq("wake_op2", issue_op2, 32'h10);
    check_eq("wake_op1", issue_op1, 32'd1);
    tick();

    // Dispatch-cycle bypass of op1
    disp(1'b0, 32'd0, 5'd9, 1'b1, 32'd2, 5'd0, 1'b1, 32'd0, 5'd0);
    cdb(5'd9, 32'hAB, 1'b0, 32'd0);
    tick(); nodisp(); nocdb();
    check_eq("bypass_iv", 32'(issue_valid), 32'd1);
    check_eq("bypass_op1", issue_op1, 32'hAB);
    check_eq("bypass_rs_id", 32'(issue_rs_id), 32'd0);
    tick();

    // XER dependency: a broadcast without XER payload must not wake it
    disp(1'b1, 32'd7, 5'd0, 1'b1, 32'd8, 5'd0, 1'b0, 32'd0, 5'd3);
    tick(); nodisp();
    cdb(5'd3, 32'h55, 1'b0, 32'h1234);
    tick(); nocdb();
    check_eq("xer_nowake_iv", 32'(issue_valid), 32'd0);
    cdb(5'd3, 32'h55, 1'b1, 32'h20000000);
    tick(); nocdb();
    check_eq("xer_wake_iv", 32'(issue_valid), 32'd1);
    check_eq("xer_wake_val", issue_xer, 32'h20000000);
    tick();
    check_eq("xer_occ_after", 32'(occupancy), 32'd0);

    // Fill all four entries under backpressure
    issue_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_eq("fill_ready", 32'(dispatch_ready), 32'd1);
      disp(1'b1, 32'h100 + 32'(i), 5'd0, 1'b1, 32'(i), 5'd0, 1'b1, 32'd0, 5'd0);
      tick();
    end
    nodisp();
    check_eq("full_ready", 32'(dispatch_ready), 32'd0);
    check_eq("full_occ", 32'(occupancy), 32'd4);
    check_eq("full_rs_id", 32'(issue_rs_id), 32'd0);
    check_eq("full_op1", issue_op1, 32'h100);

    // Dispatch while full is ignored; entry 0 stays put
    disp(1'b1, 32'hDEAD, 5'd0, 1'b1, 32'd0, 5'd0, 1'b1, 32'd0, 5'd0);
    tick(); nodisp();
    check_eq("full_ign_occ", 32'(occupancy), 32'd4);
    check_eq("full_hold_rs_id", 32'(issue_rs_id), 32'd0);
    check_eq("full_hold_op1", issue_op1, 32'h100);

    // One-cycle issue frees entry 0
    issue_ready = 1'b1;
    tick(); issue_ready = 1'b0;
    check_eq("free_occ", 32'(occupancy), 32'd3);
    check_eq("free_ready", 32'(dispatch_ready), 32'd1);
    check_eq("free_rs_id", 32'(issue_rs_id), 32'd1);
    check_eq("free_op1", issue_op1, 32'h101);

    // New dispatch lands in entry 0 and takes over selection
    disp(1'b1, 32'h200, 5'd0, 1'b1, 32'd0, 5'd0, 1'b1, 32'd0, 5'd0);
    tick(); nodisp();
    check_eq("refill_occ", 32'(occupancy), 32'd4);
    check_eq("refill_rs_id", 32'(issue_rs_id), 32'd0);
    check_eq("refill_op1", issue_op1, 32'h200);

    // Issue entry 0, then dispatch and issue in the same cycle
    issue_ready = 1'b1;
    tick();
    check_eq("drain_occ", 32'(occupancy), 32'd3);
    check_eq("drain_rs_id", 32'(issue_rs_id), 32'd1);
    disp(1'b1, 32'h300, 5'd0, 1'b1, 32'd0, 5'd0, 1'b1, 32'd0, 5'd0);
    tick(); nodisp(); issue_ready = 1'b0;
    check_eq("both_occ", 32'(occupancy), 32'd3);
    check_eq("both_rs_id", 32'(issue_rs_id), 32'd0);
    check_eq("both_op1", issue_op1, 32'h300);

    // Flush with three busy entries
    flush = 1'b1;
    check_eq("flush_cycle_iv", 32'(issue_valid), 32'd1);
    tick(); flush = 1'b0;
    check_eq("flush_occ", 32'(occupancy), 32'd0);
    check_eq("flush_iv", 32'(issue_valid), 32'd0);
    check_eq("flush_ready", 32'(dispatch_ready), 32'd1);

    // Flush wins over a same-cycle dispatch
    disp(1'b1, 32'h400, 5'd0, 1'b1, 32'd0, 5'd0, 1'b1, 32'd0, 5'd0);
    flush = 1'b1;
    tick(); flush = 1'b0; nodisp();
    check_eq("flush_prio_occ", 32'(occupancy), 32'd0);
    check_eq("flush_prio_iv", 32'(issue_valid), 32'd0);

    // Reset mid-traffic
    disp(1'b1, 32'h41, 5'd0, 1'b1, 32'd0, 5'd0, 1'b1, 32'd0, 5'd0);
    tick();
    disp(1'b1, 32'h42, 5'd0, 1'b0, 32'd0, 5'd7, 1'b1, 32'd0, 5'd0);
    tick(); nodisp();
    check_eq("pre_rst_occ", 32'(occupancy), 32'd2);
    rst = 1'b0;
    tick(); rst = 1'b1;
    check_eq("midrst_occ", 32'(occupancy), 32'd0);
    check_eq("midrst_iv", 32'(issue_valid), 32'd0);
    check_eq("midrst_ready", 32'(dispatch_ready), 32'd1);
    check_eq("midrst_op1", issue_op1, 32'd0);
    cdb(5'd7, 32'h99, 1'b0, 32'd0);
    tick(); nocdb();
    check_eq("midrst_nowake_iv", 32'(issue_valid), 32'd0);

    issue_ready = 1'b1;
    disp(1'b1, 32'h77, 5'd0, 1'b1, 32'd1, 5'd0, 1'b1, 32'd0, 5'd0);
    tick(); nodisp();
    check_eq("post_rst_iv", 32'(issue_valid), 32'd1);
    check_eq("post_rst_rs_id", 32'(issue_rs_id), 32'd0);
    check_eq("post_rst_op1", issue_op1, 32'h77);
    tick();
    check_eq("post_rst_occ", 32'(occupancy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
